cache_2way: RTL and testbench
=============================

# cache_2way

Two-way set-associative, write-back, write-allocate cache between the processor and the block-wide memory interface. It is the parametrised successor to the direct-mapped cache. It adds the following:
- configurable set count and block size;
- per-set LRU replacement;
- an optional one-entry victim write buffer, so that refills are not serialised behind write-backs.

Hits complete in the request cycle. Misses stall the processor until the block is resident.

## Interface
- `ADDR_W`, 30, processor word-address width.
- `SETS`, 4, number of sets; power of two, ≥2.
- `WORDS`, 4, 32-bit words per block; power of two, ≥2.
- Derived widths: `OFF_W = log2(WORDS)`, `IDX_W = log2(SETS)`, `TAG_W = ADDR_W - IDX_W - OFF_W`, `BLK_W = 32*WORDS`.

Ports:
- `clk` in 1: single clock, rising edge.
- `proc_reset` in 1: asynchronous, active-high reset.
- `proc_read` in 1: read request.
- `proc_write` in 1: write request.
- `proc_addr` in ADDR_W: word address, split as {tag, index, offset}.
- `proc_wdata` in 32: write data.
- `proc_stall` out 1: request not complete this cycle.
- `proc_rdata` out 32: read data, valid when `proc_read` is high and `proc_stall` is low.
- `mem_read` out 1: block read request.
- `mem_write` out 1: block write request.
- `mem_addr` out ADDR_W-OFF_W: block address.
- `mem_wdata` out BLK_W: write-back block.
- `mem_rdata` in BLK_W: refill block.
- `mem_ready` in 1: memory completes the current request this cycle.

## Operation
- Per set and per way the cache holds: valid, dirty, tag and data.
- Per set it holds one LRU bit, which names the way to evict next.
- If `proc_read` and `proc_write` are both high, the request is a read.
- **Lookup:** a hit is `valid & tag match` in either way. It is combinational on `proc_addr`.
- **Read hit:** `proc_stall`=0 and `proc_rdata` = the addressed word, in the same cycle.
- **Write hit:** the addressed word is updated and dirty is set at the next edge; `proc_stall`=0.
- **Every hit and every fill** sets LRU to the other way.
- **Victim selection:**
  - an invalid way is chosen first, way 0 before way 1;
  - otherwise the LRU way is chosen.
- **FSM states:**
  - IDLE: on a miss, go to WB if the victim is valid and dirty (and the buffer is not in use), else go to REFILL.
  - WB: assert `mem_write` with {victim tag, index}; on `mem_ready`, go to REFILL.
  - REFILL: assert `mem_read` with {proc tag, index}; on `mem_ready`, write `mem_rdata` into the victim way and go to IDLE. The fill sets valid=1, dirty=0, tag, LRU.
  - Back in IDLE, the held request now hits and completes, using the normal hit path. A write miss therefore becomes a write hit and sets dirty.
- The processor holds `proc_read`/`proc_write`/`proc_addr`/`proc_wdata` stable while `proc_stall`=1. `proc_stall`=1 in every cycle of a pending miss.
- **Memory handshake:**
  - `mem_read`/`mem_write` are registered, and are never high together.
  - `mem_addr`/`mem_wdata` stay stable while a request is high.
  - A request drops at the edge after the cycle in which `mem_ready`=1.
  - `mem_rdata` is sampled in that same cycle.

## Timing
- Reset values: `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0, state=IDLE, buffer empty. All valid, dirty and LRU bits are 0.
- `proc_stall` is combinational: 0 when idle with no request, 1 on a miss.
- Clean miss, with miss detected in cycle 0 and `mem_ready` in cycle k (k≥1): `mem_read` is high in cycles 1..k; the hit completes in cycle k+1 (`proc_stall`=0).
- Dirty miss without the buffer: write phase 1..k, then read phase k+1..m, then complete in m+1.
- Reset asserted mid-operation clears everything immediately. In-flight memory requests drop without waiting for `mem_ready`. The buffered victim is discarded.

## Configuration
- Macro `CACHE_WBUF_EN`.
- **Defined:**
  - A dirty victim is copied into a one-entry write buffer (address and block) in the miss-detect cycle, and REFILL starts immediately.
  - After the fill, the buffer drains from IDLE by asserting `mem_write` until `mem_ready`.
  - Hits are served during the drain.
  - Any new miss stalls in IDLE until the buffer is empty. This also avoids refilling stale data for the buffered block.
  - Dirty-miss latency equals clean-miss latency.
- **Undefined:** there is no buffer, and the WB→REFILL sequence above applies.

## Test plan
All scenarios use SETS=4, WORDS=4 (tag = `proc_addr[29:4]`, index = `[3:2]`, offset = `[1:0]`), with a memory model of ready latency 3 cycles.
- **Reset state:** reset, then read addr 0x10 → `mem_read` with `mem_addr`=0x4 in cycles 1–3. Then `proc_rdata` = word 0 of the block, with `proc_stall`=0 in cycle 4.
- **Write-hit latency:** write 0xDEADBEEF to 0x11, then read 0x11 → the read completes in its request cycle with `proc_stall`=0 and `proc_rdata`=0xDEADBEEF.
- **Two ways, no eviction:** fill 0x10 and 0x50 (same set) → both hit afterwards.
- **LRU eviction:** after the previous scenario, touch 0x10, then read 0x90 → the 0x50 way is evicted and 0x10 still hits.
- **Dirty eviction without `CACHE_WBUF_EN`:** after the 0xDEADBEEF write to 0x11, force eviction of that way → `mem_write` to `mem_addr`=0x4 carrying 0xDEADBEEF in word 1, strictly before `mem_read`.
- **Dirty eviction with `CACHE_WBUF_EN`:** same stimulus → `mem_read` first. A hit issued during the drain returns with `proc_stall`=0. A second miss during the drain stalls until `mem_write` completes.
- **Reset mid-operation:** assert `proc_reset` during `mem_read` → `mem_read`=0 immediately, and a subsequent access to 0x10 misses.

Source files
------------

// File: rtl/cache_2way.sv
// cache_2way: two-way set-associative, write-back, write-allocate cache.
// Hits complete in the request cycle; misses stall until the block is resident.
// Optional feature macro: CACHE_WBUF_EN (one-entry victim write buffer so the
// refill is not serialised behind the write-back of a dirty victim).
module cache_2way #(
    parameter int ADDR_W = 30,
    parameter int SETS   = 4,
    parameter int WORDS  = 4
) (
    input  logic                              clk,
    input  logic                              proc_reset,
    input  logic                              proc_read,
    input  logic                              proc_write,
    input  logic [ADDR_W-1:0]                 proc_addr,
    input  logic [31:0]                       proc_wdata,
    output logic                              proc_stall,
    output logic [31:0]                       proc_rdata,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_W-$clog2(WORDS)-1:0]   mem_addr,
    output logic [32*WORDS-1:0]               mem_wdata,
    input  logic [32*WORDS-1:0]               mem_rdata,
    input  logic                              mem_ready
);
    localparam int OFF_W   = $clog2(WORDS);
    localparam int IDX_W   = $clog2(SETS);
    localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
    localparam int BLK_W   = 32 * WORDS;
    localparam int MADDR_W = ADDR_W - OFF_W;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_REFILL} state_t;

    // Per-way storage; the LRU bit names the way to evict next
    logic             valid_q [2][SETS];
    logic             dirty_q [2][SETS];
    logic [TAG_W-1:0] tag_q   [2][SETS];
    logic [BLK_W-1:0] data_q  [2][SETS];
    logic             lru_q   [SETS];

    state_t               state_q, state_d;
    logic                 mem_read_q, mem_read_d;
    logic                 mem_write_q, mem_write_d;
    logic [MADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [BLK_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                 victim_q, victim_d;

`ifdef CACHE_WBUF_EN
    logic                 wbuf_valid_q, wbuf_valid_d;
    logic [MADDR_W-1:0]   wbuf_addr_q, wbuf_addr_d;
    logic [BLK_W-1:0]     wbuf_data_q, wbuf_data_d;
`endif

    // Address split and request decode (a simultaneous read+write is a read)
    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic [OFF_W-1:0] req_off;
    logic             req, req_is_write;

    assign req_tag      = proc_addr[ADDR_W-1 -: TAG_W];
    assign req_idx      = proc_addr[OFF_W +: IDX_W];
    assign req_off      = proc_addr[OFF_W-1:0];
    assign req          = proc_read | proc_write;
    assign req_is_write = proc_write & ~proc_read;

    logic [1:0] hit_vec;
    for (genvar gi = 0; gi < 2; gi++) begin : g_way
        assign hit_vec[gi] = valid_q[gi][req_idx] && (tag_q[gi][req_idx] == req_tag);
    end

    logic hit, hit_way, hit_en, hit_wr_en, fill_en;
    logic victim_way, victim_dirty;
    logic [MADDR_W-1:0] victim_addr;
    logic [BLK_W-1:0]   victim_data;

    assign hit       = |hit_vec;
    assign hit_way   = ~hit_vec[0];
    assign hit_en    = (state_q == S_IDLE) && req && hit;
    assign hit_wr_en = hit_en && req_is_write;

    // Invalid way first (way 0 before way 1), otherwise the LRU way
    assign victim_way   = !valid_q[0][req_idx] ? 1'b0 :
                          !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
    assign victim_dirty = valid_q[victim_way][req_idx] && dirty_q[victim_way][req_idx];
    assign victim_addr  = {tag_q[victim_way][req_idx], req_idx};
    assign victim_data  = data_q[victim_way][req_idx];

    assign proc_stall = (state_q != S_IDLE) || (req && !hit);
    assign proc_rdata = data_q[hit_way][req_idx][req_off*32 +: 32];
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    // Miss FSM next-state and memory request generation
    always_comb begin
        state_d     = state_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        victim_d    = victim_q;
        fill_en     = 1'b0;
`ifdef CACHE_WBUF_EN
        wbuf_valid_d = wbuf_valid_q;
        wbuf_addr_d  = wbuf_addr_q;
        wbuf_data_d  = wbuf_data_q;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef CACHE_WBUF_EN
                // A new miss waits for an empty buffer so a buffered block is never refilled stale
                if (req && !hit && !wbuf_valid_q) begin
                    if (victim_dirty) begin
                        wbuf_valid_d = 1'b1;
                        wbuf_addr_d  = victim_addr;
                        wbuf_data_d  = victim_data;
                    end
                    victim_d   = victim_way;
                    state_d    = S_REFILL;
                    mem_read_d = 1'b1;
                    mem_addr_d = {req_tag, req_idx};
                end
                // Drain the buffer while idle; hits keep being served meanwhile
                if (wbuf_valid_q) begin
                    if (!mem_write_q) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = wbuf_addr_q;
                        mem_wdata_d = wbuf_data_q;
                    end else if (mem_ready) begin
                        mem_write_d  = 1'b0;
                        wbuf_valid_d = 1'b0;
                    end
                end
`else
                if (req && !hit) begin
                    victim_d = victim_way;
                    if (victim_dirty) begin
                        state_d     = S_WB;
                        mem_write_d = 1'b1;
                        mem_addr_d  = victim_addr;
                        mem_wdata_d = victim_data;
                    end else begin
                        state_d    = S_REFILL;
                        mem_read_d = 1'b1;
                        mem_addr_d = {req_tag, req_idx};
                    end
                end
`endif
            end
            S_WB: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {req_tag, req_idx};
                    state_d     = S_REFILL;
                end
            end
            S_REFILL: begin
                if (mem_ready) begin
                    mem_read_d = 1'b0;
                    fill_en    = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, status bits and memory request registers
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state_q     <= S_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            victim_q    <= 1'b0;
`ifdef CACHE_WBUF_EN
            wbuf_valid_q <= 1'b0;
            wbuf_addr_q  <= '0;
            wbuf_data_q  <= '0;
`endif
            for (int s = 0; s < SETS; s++) begin
                lru_q[s]      <= 1'b0;
                valid_q[0][s] <= 1'b0;
                valid_q[1][s] <= 1'b0;
                dirty_q[0][s] <= 1'b0;
                dirty_q[1][s] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            victim_q    <= victim_d;
`ifdef CACHE_WBUF_EN
            wbuf_valid_q <= wbuf_valid_d;
            wbuf_addr_q  <= wbuf_addr_d;
            wbuf_data_q  <= wbuf_data_d;
`endif
            if (hit_en)
                lru_q[req_idx] <= ~hit_way;
            if (hit_wr_en)
                dirty_q[hit_way][req_idx] <= 1'b1;
            if (fill_en) begin
                valid_q[victim_q][req_idx] <= 1'b1;
                dirty_q[victim_q][req_idx] <= 1'b0;
                lru_q[req_idx]             <= ~victim_q;
            end
        end
    end

    // Tag and data arrays need no reset: valid bits gate every use
    always_ff @(posedge clk) begin
        if (hit_wr_en)
            data_q[hit_way][req_idx][req_off*32 +: 32] <= proc_wdata;
        if (fill_en) begin
            data_q[victim_q][req_idx] <= mem_rdata;
            tag_q[victim_q][req_idx]  <= req_tag;
        end
    end
endmodule

// File: tb/tb_cache_2way.sv
// tb_cache_2way: directed bench for cache_2way with a 3-cycle-latency memory.
// Memory word at word address a holds 0xA0000000 + a until written back.
module tb_cache_2way;
    logic         clk = 1'b0;
    logic         proc_reset;
    logic         proc_read, proc_write;
    logic [29:0]  proc_addr;
    logic [31:0]  proc_wdata;
    logic         proc_stall;
    logic [31:0]  proc_rdata;
    logic         mem_read, mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata, mem_rdata;
    logic         mem_ready;

    int checks = 0;
    int failures = 0;

    cache_2way #(.ADDR_W(30), .SETS(4), .WORDS(4)) dut (
        .clk(clk), .proc_reset(proc_reset),
        .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata),
        .proc_stall(proc_stall), .proc_rdata(proc_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Memory model: ready in the third cycle of a request; reset restores the pattern
    logic [127:0] mem_m [64];
    int lat_cnt;
    assign mem_ready = (mem_read || mem_write) && (lat_cnt == 2);
    assign mem_rdata = mem_m[mem_addr[5:0]];
    always @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            lat_cnt <= 0;
            for (int b = 0; b < 64; b++)
                for (int i = 0; i < 4; i++)
                    mem_m[b][i*32 +: 32] <= 32'hA000_0000 + 32'(b*4 + i);
        end else if (mem_read || mem_write) begin
            if (mem_ready) begin
                lat_cnt <= 0;
                if (mem_write) mem_m[mem_addr[5:0]] <= mem_wdata;
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // Results of the most recent access (cycle numbers relative to request cycle 0)
    int           acc_lat, first_rd, first_wr, rd_cnt, wr_cnt, both_cnt;
    logic [31:0]  acc_rdata;
    logic [27:0]  rd_addr, wr_addr;
    logic [127:0] wr_data;

    // Apply one request (entered at posedge+1) and hold it until proc_stall drops
    task automatic access(input logic wr, input logic [29:0] a, input logic [31:0] d);
        proc_read  = !wr;
        proc_write = wr;
        proc_addr  = a;
        proc_wdata = d;
        acc_lat = -1; first_rd = -1; first_wr = -1;
        rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
        acc_rdata = '0; rd_addr = '0; wr_addr = '0; wr_data = '0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (mem_read && mem_write) both_cnt++;
            if (mem_read) begin
                if (first_rd < 0) begin first_rd = c; rd_addr = mem_addr; end
                rd_cnt++;
            end
            if (mem_write) begin
                if (first_wr < 0) begin first_wr = c; wr_addr = mem_addr; wr_data = mem_wdata; end
                wr_cnt++;
            end
            if (!proc_stall) begin
                acc_lat = c;
                acc_rdata = proc_rdata;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        proc_read  = 1'b0;
        proc_write = 1'b0;
        $display("access %s addr=%h lat=%0d rdata=%h rd@%0d wr@%0d", wr ? "W" : "R", a, acc_lat, acc_rdata, first_rd, first_wr);
        checks++;
        if (both_cnt !== 0) begin
            failures++;
            $display("FAIL mem_excl addr=%h got %0d cycles with read+write, want 0", a, both_cnt);
        end
    endtask

    task automatic test_reset;
        proc_reset = 1'b1; proc_read = 1'b0; proc_write = 1'b0;
        proc_addr = '0; proc_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_read, mem_write, proc_stall} !== 3'b000 || mem_addr !== 28'h0 || mem_wdata !== 128'h0) begin
            failures++;
            $display("FAIL reset_outputs got rd=%b wr=%b stall=%b addr=%h wdata=%h, want all 0",
                     mem_read, mem_write, proc_stall, mem_addr, mem_wdata);
        end
        @(posedge clk); #1;
        proc_reset = 1'b0;
        access(1'b0, 30'h10, 32'h0);
        checks++;
        if (first_rd !== 1 || rd_cnt !== 3 || rd_addr !== 28'h4) begin
            failures++;
            $display("FAIL reset_refill got first=%0d cnt=%0d addr=%h, want 1 3 4", first_rd, rd_cnt, rd_addr);
        end
        checks++;
        if (acc_lat !== 4 || acc_rdata !== 32'hA000_0010) begin
            failures++;
            $display("FAIL reset_complete got lat=%0d data=%h, want 4 a0000010", acc_lat, acc_rdata);
        end
    endtask

    task automatic test_write_hit;
        access(1'b1, 30'h11, 32'hDEAD_BEEF);
        checks++;
        if (acc_lat !== 0 || rd_cnt !== 0) begin
            failures++;
            $display("FAIL write_hit got lat=%0d rdcycles=%0d, want 0 0", acc_lat, rd_cnt);
        end
        access(1'b0, 30'h11, 32'h0);
        checks++;
        if (acc_lat !== 0 || acc_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL read_after_write got lat=%0d data=%h, want 0 deadbeef", acc_lat, acc_rdata);
        end
        access(1'b0, 30'h12, 32'h0);
        checks++;
        if (acc_lat !== 0 || acc_rdata !== 32'hA000_0012) begin
            failures++;
            $display("FAIL neighbour_word got lat=%0d data=%h, want 0 a0000012", acc_lat, acc_rdata);
        end
    endtask

    task automatic test_two_ways;
        access(1'b0, 30'h50, 32'h0);
        checks++;
        if (acc_lat !== 4 || rd_addr !== 28'h14 || acc_rdata !== 32'hA000_0050) begin
            failures++;
            $display("FAIL fill_second_way got lat=%0d addr=%h data=%h, want 4 14 a0000050", acc_lat, rd_addr, acc_rdata);
        end
        access(1'b0, 30'h10, 32'h0);
        checks++;
        if (acc_lat !== 0 || acc_rdata !== 32'hA000_0010) begin
            failures++;
            $display("FAIL way0_hit got lat=%0d data=%h, want 0 a0000010", acc_lat, acc_rdata);
        end
        access(1'b0, 30'h53, 32'h0);
        checks++;
        if (acc_lat !== 0 || acc_rdata !== 32'hA000_0053) begin
            failures++;
            $display("FAIL way1_hit got lat=%0d data=%h, want 0 a0000053", acc_lat, acc_rdata);
        end
    endtask

    task automatic test_lru_eviction;
        access(1'b0, 30'h10, 32'h0);
        access(1'b0, 30'h90, 32'h0);
        checks++;
        if (acc_lat !== 4 || first_wr !== -1 || rd_addr !== 28'h24 || acc_rdata !== 32'hA000_0090) begin
            failures++;
            $display("FAIL lru_miss got lat=%0d wr@%0d addr=%h data=%h, want 4 -1 24 a0000090",
                     acc_lat, first_wr, rd_addr, acc_rdata);
        end
        access(1'b0, 30'h10, 32'h0);
        checks++;
        if (acc_lat !== 0) begin
            failures++;
            $display("FAIL lru_kept_way got lat=%0d, want 0", acc_lat);
        end
    endtask

    // Set 0 now holds 0x10 (dirty, way 0) and 0x90 (way 1); touching 0x90 makes way 0 the victim
    task automatic test_dirty_eviction;
        access(1'b0, 30'h90, 32'h0);
        access(1'b0, 30'hD0, 32'h0);
`ifdef CACHE_WBUF_EN
        checks++;
        if (first_rd !== 1 || first_wr !== -1 || acc_lat !== 4 || acc_rdata !== 32'hA000_00D0) begin
            failures++;
            $display("FAIL wbuf_refill_first got rd@%0d wr@%0d lat=%0d data=%h, want 1 -1 4 a00000d0",
                     first_rd, first_wr, acc_lat, acc_rdata);
        end
        access(1'b0, 30'h91, 32'h0);
        checks++;
        if (acc_lat !== 0 || wr_cnt !== 1 || wr_addr !== 28'h4 || wr_data[63:32] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL hit_during_drain got lat=%0d wrcycles=%0d addr=%h word1=%h, want 0 1 4 deadbeef",
                     acc_lat, wr_cnt, wr_addr, wr_data[63:32]);
        end
        access(1'b0, 30'h11, 32'h0);
        checks++;
        if (wr_cnt !== 2 || first_rd !== 3 || acc_lat !== 6 || acc_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL miss_during_drain got wrcycles=%0d rd@%0d lat=%0d data=%h, want 2 3 6 deadbeef",
                     wr_cnt, first_rd, acc_lat, acc_rdata);
        end
`else
        checks++;
        if (first_wr !== 1 || wr_cnt !== 3 || wr_addr !== 28'h4 || wr_data[63:32] !== 32'hDEAD_BEEF
            || wr_data[31:0] !== 32'hA000_0010) begin
            failures++;
            $display("FAIL writeback got wr@%0d cnt=%0d addr=%h data=%h, want 1 3 4 word1=deadbeef",
                     first_wr, wr_cnt, wr_addr, wr_data);
        end
        checks++;
        if (first_rd !== 4 || rd_cnt !== 3 || rd_addr !== 28'h34 || acc_lat !== 7 || acc_rdata !== 32'hA000_00D0) begin
            failures++;
            $display("FAIL refill_after_wb got rd@%0d cnt=%0d addr=%h lat=%0d data=%h, want 4 3 34 7 a00000d0",
                     first_rd, rd_cnt, rd_addr, acc_lat, acc_rdata);
        end
        access(1'b0, 30'h11, 32'h0);
        checks++;
        if (acc_lat !== 4 || acc_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL written_back_data got lat=%0d data=%h, want 4 deadbeef", acc_lat, acc_rdata);
        end
`endif
    endtask

    task automatic test_reset_mid;
        proc_read = 1'b1; proc_write = 1'b0; proc_addr = 30'h20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (mem_read !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_setup got mem_read=%b, want 1", mem_read);
        end
        proc_reset = 1'b1;
        #1;
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_addr !== 28'h0) begin
            failures++;
            $display("FAIL mid_reset_drop got rd=%b wr=%b addr=%h, want 0 0 0", mem_read, mem_write, mem_addr);
        end
        proc_read = 1'b0;
        @(posedge clk); #1;
        proc_reset = 1'b0;
        access(1'b0, 30'h10, 32'h0);
        checks++;
        if (first_rd !== 1 || acc_lat !== 4 || acc_rdata !== 32'hA000_0010) begin
            failures++;
            $display("FAIL post_reset_miss got rd@%0d lat=%0d data=%h, want 1 4 a0000010", first_rd, acc_lat, acc_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_write_hit();
        test_two_ways();
        test_lru_eviction();
        test_dirty_eviction();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
